// File: rtl/axi_lite_pkg.sv
// AXI4-Lite shared definitions: response codes and data/strobe widths.
// Latency: n/a (constants only).
// Backpressure: n/a. Shared by the master and slave sides of the AXI-Lite link.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

endpackage

// File: rtl/axi_lite_s_regfile.sv
// Register array behind the AXI-Lite slave: byte-strobe merge, flat reg_q, commit pulses.
// Latency: write visible on reg_q_o one cycle after wr_en_i; rd_data_o is combinational.
// Backpressure: none; accepts a write every cycle wr_en_i is high.
// Ports: clk_i/rst_ni clock and async active-low reset; wr_en_i/wr_idx_i/wr_data_i/wr_strb_i
// write request; rd_idx_i/rd_data_o read port; reg_q_o flat contents; reg_wr_o commit pulses.
module axi_lite_s_regfile
    import axi_lite_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int IDX_W    = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         wr_en_i,
    input  logic [IDX_W-1:0]             wr_idx_i,
    input  logic [DATA_W-1:0]            wr_data_i,
    input  logic [STRB_W-1:0]            wr_strb_i,
    input  logic [IDX_W-1:0]             rd_idx_i,
    output logic [DATA_W-1:0]            rd_data_o,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q_o,
    output logic [NUM_REGS-1:0]          reg_wr_o
);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] reg_wr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            reg_wr_q <= '0;
        end else begin
            reg_wr_q <= '0;
            if (wr_en_i) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (wr_strb_i[b]) begin
                        regs_q[wr_idx_i][8*b +: 8] <= wr_data_i[8*b +: 8];
                    end
                end
                // Pulse lines up with the cycle the new value first appears on reg_q_o.
                reg_wr_q[wr_idx_i] <= 1'b1;
            end
        end
    end

    // Caller masks out-of-range indices, so no bounds handling here.
    assign rd_data_o = regs_q[rd_idx_i];
    assign reg_wr_o  = reg_wr_q;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
        assign reg_q_o[DATA_W*i +: DATA_W] = regs_q[i];
    end

endmodule

// File: rtl/axi_lite_s_regs.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit registers as a flat vector with commit pulses.
// Latency: bvalid one cycle after the later AW/W handshake; rvalid one cycle after AR.
// Backpressure: AW/W stall while a beat is held or B is pending; AR stalls while R is pending.
// Ports: aclk/aresetn; s_axi_aw*/w*/b* write channels; s_axi_ar*/r* read channels;
// reg_q flat register contents (reg i at [32*i+31:32*i]); reg_wr per-register commit pulse.
module axi_lite_s_regs
    import axi_lite_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 32
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [ADDR_W-1:0]           s_axi_awaddr,
    input  logic [2:0]                  s_axi_awprot,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [DATA_W-1:0]           s_axi_wdata,
    input  logic [STRB_W-1:0]           s_axi_wstrb,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    output logic [1:0]                  s_axi_bresp,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    input  logic [ADDR_W-1:0]           s_axi_araddr,
    input  logic [2:0]                  s_axi_arprot,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    output logic [DATA_W-1:0]           s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready,
    output logic [NUM_REGS*DATA_W-1:0]  reg_q,
    output logic [NUM_REGS-1:0]         reg_wr
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [0:0] R_IDLE  = 1'b0;
    localparam logic [0:0] R_VALID = 1'b1;

    // Word index is addr >> 2; anything at or beyond NUM_REGS is out of range.
    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return (addr >> 2) < ADDR_W'(NUM_REGS);
    endfunction

    // ---------------- write path ----------------
    logic                aw_have_q, aw_have_d;
    logic                w_have_q,  w_have_d;
    logic                bvalid_q,  bvalid_d;
    logic [1:0]          bresp_q,   bresp_d;
    logic [ADDR_W-1:0]   awaddr_q,  awaddr_d;
    logic [DATA_W-1:0]   wdata_q,   wdata_d;
    logic [STRB_W-1:0]   wstrb_q,   wstrb_d;

    logic aw_hs, w_hs, commit, wr_in_range;

    assign s_axi_awready = !aw_have_q && !bvalid_q;
    assign s_axi_wready  = !w_have_q  && !bvalid_q;
    assign aw_hs         = s_axi_awvalid && s_axi_awready;
    assign w_hs          = s_axi_wvalid  && s_axi_wready;
    assign commit        = aw_have_q && w_have_q && !bvalid_q;
    assign wr_in_range   = in_range(awaddr_q);

    // aw_hs/w_hs require their flag clear while commit requires it set, so they never collide.
    always_comb begin
        aw_have_d = aw_have_q;
        w_have_d  = w_have_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        if (aw_hs) begin
            aw_have_d = 1'b1;
            awaddr_d  = s_axi_awaddr;
        end
        if (w_hs) begin
            w_have_d = 1'b1;
            wdata_d  = s_axi_wdata;
            wstrb_d  = s_axi_wstrb;
        end
        if (commit) begin
            aw_have_d = 1'b0;
            w_have_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = wr_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (bvalid_q && s_axi_bready) begin
            bvalid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_have_q <= 1'b0;
            w_have_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            aw_have_q <= aw_have_d;
            w_have_q  <= w_have_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
        end
    end

    assign s_axi_bvalid = bvalid_q;
    assign s_axi_bresp  = bresp_q;

    // ---------------- register bank ----------------
    logic [DATA_W-1:0] rd_data;

    axi_lite_s_regfile #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_regfile (
        .clk_i     (aclk),
        .rst_ni    (aresetn),
        .wr_en_i   (commit && wr_in_range),
        .wr_idx_i  (awaddr_q[IDX_W+1:2]),
        .wr_data_i (wdata_q),
        .wr_strb_i (wstrb_q),
        .rd_idx_i  (s_axi_araddr[IDX_W+1:2]),
        .rd_data_o (rd_data),
        .reg_q_o   (reg_q),
        .reg_wr_o  (reg_wr)
    );

    // ---------------- read path ----------------
    logic [0:0]        r_state_q, r_state_d;
    logic [DATA_W-1:0] rdata_q,   rdata_d;
    logic [1:0]        rresp_q,   rresp_d;

    // rdata is sampled from the array before this edge's write lands, so a read
    // coinciding with a commit to the same register returns the old value.
    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (s_axi_arvalid) begin
                    r_state_d = R_VALID;
                    rdata_d   = in_range(s_axi_araddr) ? rd_data : '0;
                    rresp_d   = in_range(s_axi_araddr) ? RESP_OKAY : RESP_SLVERR;
                end
            end
            default: begin
                if (s_axi_rready) begin
                    r_state_d = R_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state_q <= R_IDLE;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign s_axi_arready = (r_state_q == R_IDLE);
    assign s_axi_rvalid  = (r_state_q == R_VALID);
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;

    // Protection bits and byte offsets carry no meaning for this register bank.
    logic unused_bits;
    assign unused_bits = ^{s_axi_awprot, s_axi_arprot, awaddr_q[1:0], s_axi_araddr[1:0]};

endmodule

// File: tb/tb_axi_lite_s_regs.sv
module tb_axi_lite_s_regs;
    import axi_lite_pkg::*;

    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = 32;

    logic                       aclk = 1'b0;
    logic                       aresetn;
    logic [ADDR_W-1:0]          awaddr;
    logic [2:0]                 awprot;
    logic                       awvalid, awready;
    logic [31:0]                wdata;
    logic [3:0]                 wstrb;
    logic                       wvalid, wready;
    logic [1:0]                 bresp;
    logic                       bvalid, bready;
    logic [ADDR_W-1:0]          araddr;
    logic [2:0]                 arprot;
    logic                       arvalid, arready;
    logic [31:0]                rdata;
    logic [1:0]                 rresp;
    logic                       rvalid, rready;
    logic [NUM_REGS*32-1:0]     reg_q;
    logic [NUM_REGS-1:0]        reg_wr;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain array of register words.
    logic [31:0] model [NUM_REGS];

    always #5 aclk = ~aclk;

    axi_lite_s_regs #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axi_awaddr  (awaddr),
        .s_axi_awprot  (awprot),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_araddr  (araddr),
        .s_axi_arprot  (arprot),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .reg_q         (reg_q),
        .reg_wr        (reg_wr)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NUM_REGS*32-1:0] model_flat();
        logic [NUM_REGS*32-1:0] v;
        for (int i = 0; i < NUM_REGS; i++) v[32*i +: 32] = model[i];
        return v;
    endfunction

    function automatic bit addr_ok(input logic [31:0] addr);
        return (addr / 4) < NUM_REGS;
    endfunction

    function automatic int widx(input logic [31:0] addr);
        return int'(addr / 4);
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Full write transaction; caller is at posedge+1.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int stall);
        bit aw_done = 0;
        bit w_done  = 0;
        bit aw_hs, w_hs;
        int cyc = 0;
        logic [1:0] exp_resp;
        logic [NUM_REGS-1:0] exp_wr;
        bready = 1'b0;
        while (!(aw_done && w_done) && cyc < 64) begin
            awvalid = !aw_done && (cyc >= aw_dly);
            awaddr  = addr;
            wvalid  = !w_done && (cyc >= w_dly);
            wdata   = data;
            wstrb   = strb;
            aw_hs   = awvalid && awready;
            w_hs    = wvalid && wready;
            check("b_idle", bvalid, 1'b0);
            tick();
            aw_done |= aw_hs;
            w_done  |= w_hs;
            cyc++;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check("aw_w_accepted", {aw_done, w_done}, 2'b11);
        check("b_not_yet", bvalid, 1'b0);
        bready = (stall == 0);
        tick();
        exp_wr = '0;
        if (addr_ok(addr)) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) model[widx(addr)][8*b +: 8] = data[8*b +: 8];
            exp_wr[widx(addr)] = 1'b1;
            exp_resp = RESP_OKAY;
        end else begin
            exp_resp = RESP_SLVERR;
        end
        check("bvalid", bvalid, 1'b1);
        check("bresp", bresp, exp_resp);
        check("reg_wr", reg_wr, exp_wr);
        check("reg_q", reg_q, model_flat());
        for (int k = 0; k < stall; k++) begin
            awvalid = 1'b1;
            wvalid  = 1'b1;
            tick();
            check("b_hold", bvalid, 1'b1);
            check("bresp_hold", bresp, exp_resp);
            check("awready_stall", awready, 1'b0);
            check("wready_stall", wready, 1'b0);
            check("reg_wr_once", reg_wr, '0);
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b1;
        tick();
        check("b_done", bvalid, 1'b0);
        check("reg_wr_clear", reg_wr, '0);
        check("awready_free", awready, 1'b1);
        bready = 1'b0;
    endtask

    task automatic read_issue(input logic [31:0] addr, output logic [31:0] exp_d, output logic [1:0] exp_r);
        araddr  = addr;
        arvalid = 1'b1;
        check("arready", arready, 1'b1);
        exp_d = addr_ok(addr) ? model[widx(addr)] : 32'h0;
        exp_r = addr_ok(addr) ? RESP_OKAY : RESP_SLVERR;
        tick();
        arvalid = 1'b0;
        check("rvalid", rvalid, 1'b1);
        check("rdata", rdata, exp_d);
        check("rresp", rresp, exp_r);
        check("arready_busy", arready, 1'b0);
    endtask

    task automatic read_finish(input int stall, input logic [31:0] exp_d, input logic [1:0] exp_r);
        for (int k = 0; k < stall; k++) begin
            tick();
            check("r_hold", rvalid, 1'b1);
            check("rdata_hold", rdata, exp_d);
            check("rresp_hold", rresp, exp_r);
        end
        rready = 1'b1;
        tick();
        check("r_done", rvalid, 1'b0);
        check("arready_back", arready, 1'b1);
        rready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input int stall);
        logic [31:0] d;
        logic [1:0]  r;
        read_issue(addr, d, r);
        read_finish(stall, d, r);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_awready"}, awready, 1'b1);
        check({tag, "_wready"},  wready,  1'b1);
        check({tag, "_arready"}, arready, 1'b1);
        check({tag, "_bvalid"},  bvalid,  1'b0);
        check({tag, "_rvalid"},  rvalid,  1'b0);
        check({tag, "_bresp"},   bresp,   2'b00);
        check({tag, "_rresp"},   rresp,   2'b00);
        check({tag, "_rdata"},   rdata,   32'h0);
        check({tag, "_reg_q"},   reg_q,   '0);
        check({tag, "_reg_wr"},  reg_wr,  '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] od;
        logic [1:0]  orr;
        logic [31:0] a, d, old;

        aresetn = 1'b0;
        awaddr = '0; awprot = 3'b000; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = 3'b000; arvalid = 1'b0; rready = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;

        #12;
        check_reset_outputs("in_reset");
        @(negedge aclk);
        aresetn = 1'b1;
        tick();
        check_reset_outputs("after_reset");

        // Basic write with AW/W together, then read back.
        axi_write(32'h04, 32'hA5A5_1234, 4'hF, 0, 0, 0);
        check("reg1_val", reg_q[63:32], 32'hA5A5_1234);
        axi_read(32'h04, 0);

        // Byte strobes with W leading AW, then AW leading W.
        axi_write(32'h08, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        axi_write(32'h08, 32'h0000_0000, 4'b0101, 3, 0, 0);
        check("strb_w_first", reg_q[95:64], 32'hFF00_FF00);
        axi_write(32'h08, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        axi_write(32'h08, 32'h0000_0000, 4'b0101, 0, 5, 0);
        check("strb_aw_first", reg_q[95:64], 32'hFF00_FF00);
        axi_read(32'h0A, 1);

        // Out-of-range accesses.
        axi_write(32'h20, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
        axi_read(32'h3C, 0);
        axi_write(32'h1000_0004, 32'h1234_5678, 4'hF, 1, 0, 0);

        // B backpressure.
        axi_write(32'h10, 32'h0BAD_F00D, 4'hF, 0, 0, 10);
        axi_write(32'h14, 32'h7777_8888, 4'hF, 0, 0, 0);

        // Read held with rready low while a write to the same register completes.
        read_issue(32'h0C, od, orr);
        axi_write(32'h0C, 32'hCAFE_0001, 4'hF, 0, 1, 0);
        read_finish(2, od, orr);
        axi_read(32'h0C, 0);

        // AR handshake on the same edge as a commit to the same register.
        old = model[4];
        awaddr = 32'h10; wdata = 32'h5555_AAAA; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 32'h10; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        model[4] = 32'h5555_AAAA;
        check("coinc_rvalid", rvalid, 1'b1);
        check("coinc_rdata_old", rdata, old);
        check("coinc_bvalid", bvalid, 1'b1);
        check("coinc_reg_q", reg_q, model_flat());
        rready = 1'b1;
        tick();
        check("coinc_r_done", rvalid, 1'b0);
        check("coinc_b_done", bvalid, 1'b0);
        rready = 1'b0; bready = 1'b0;

        // Randomized mix of writes and reads against the model.
        for (int n = 0; n < 60; n++) begin
            a = ($urandom_range(0, 11) << 2) | $urandom_range(0, 3);
            d = $urandom;
            if ($urandom_range(0, 1) == 1)
                axi_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 2));
            else
                axi_read(a, $urandom_range(0, 2));
        end
        check("rand_reg_q", reg_q, model_flat());

        // Reset while both B and R are outstanding.
        awaddr = 32'h00; wdata = 32'h1357_9BDF; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; araddr = 32'h04; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        tick();
        check("pre_rst_bvalid", bvalid, 1'b1);
        check("pre_rst_rvalid", rvalid, 1'b1);
        #2;
        aresetn = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
        @(negedge aclk);
        aresetn = 1'b1;
        bready = 1'b1; rready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("post_rst_no_b", bvalid, 1'b0);
            check("post_rst_no_r", rvalid, 1'b0);
        end
        bready = 1'b0; rready = 1'b0;
        axi_write(32'h1C, 32'h2468_ACE0, 4'b1100, 0, 0, 0);
        axi_read(32'h1C, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
